// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus split read/write memory port of the lsu.
interface lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_acc_i;
  logic        req_sext_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        mem_r_en_o;
  logic        mem_sext_o;
  logic [1:0]  mem_acc_r_o;
  logic [31:0] mem_addr_r_o;
  logic [31:0] mem_data_r_i;
  logic        mem_wr_en_o;
  logic [1:0]  mem_acc_w_o;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_data_w_o;
  logic        mem_wr_ready_i;
  modport slave (
    input  req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i, req_data_i,
    input  mem_data_r_i, mem_wr_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o,
    output mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o
  );
  modport master (
    output req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i, req_data_i,
    output mem_data_r_i, mem_wr_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o,
    input  mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o
  );
endinterface

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit bridging a request port to a split read/write memory port.
module lsu #(
  parameter logic [31:0] MAP_ZERO = 32'h0,
  parameter int          ROWS     = 512
) (
  input logic clk_i,
  input logic rstn_i,
  lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, STORE, COMMIT, RESP} state_t;
  localparam logic [32:0] LO = {1'b0, MAP_ZERO};
  localparam logic [32:0] HI = LO + 33'(ROWS) * 33'd4;
  state_t      state_q, state_d;
  logic        we_q, sext_q, rsp_err_q;
  logic [1:0]  acc_q;
  logic [31:0] addr_q, data_q, rsp_data_q;
  logic        misaligned, out_of_range, bad, accept, ld, st;
  // 2'b11 is treated as a word access
  assign misaligned   = bus.req_acc_i == 2'b00 ? 1'b0 :
                        bus.req_acc_i == 2'b01 ? bus.req_addr_i[0] : |bus.req_addr_i[1:0];
  assign out_of_range = {1'b0, bus.req_addr_i} < LO || {1'b0, bus.req_addr_i} >= HI;
  assign bad          = misaligned | out_of_range;
  assign accept       = state_q == IDLE && bus.req_valid_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !bus.req_valid_i ? IDLE : bad ? RESP : bus.req_we_i ? STORE : LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = RESP;
      STORE:   state_d = bus.mem_wr_ready_i ? COMMIT : STORE;
      COMMIT:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      acc_q      <= 2'b00;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= bus.req_we_i;
        sext_q <= bus.req_sext_i;
        acc_q  <= bus.req_acc_i;
        addr_q <= bus.req_addr_i;
        data_q <= bus.req_data_i;
      end
      // response registers change only on entry to RESP so they hold until the next one
      if (state_d == RESP && state_q != RESP) begin
        rsp_err_q  <= state_q == IDLE;
        rsp_data_q <= state_q == LOAD_B ? bus.mem_data_r_i : '0;
      end
    end
  assign ld = state_q == LOAD_A || state_q == LOAD_B;
  assign st = state_q == STORE || state_q == COMMIT;
  assign bus.req_ready_o  = state_q == IDLE;
  assign bus.rsp_valid_o  = state_q == RESP;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.mem_r_en_o   = ld;
  assign bus.mem_sext_o   = ld ? sext_q : 1'b0;
  assign bus.mem_acc_r_o  = ld ? acc_q : 2'b00;
  assign bus.mem_addr_r_o = ld ? addr_q : '0;
  assign bus.mem_wr_en_o  = state_q == STORE;
  assign bus.mem_acc_w_o  = st ? acc_q : 2'b00;
  assign bus.mem_addr_w_o = st ? addr_q : '0;
  assign bus.mem_data_w_o = st ? data_q : '0;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table vectors, a reset-in-COMMIT sequence and random traffic checked against an address/size model.
module tb_lsu;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;
  lsu_if bus();
  lsu dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));
  localparam longint MZ = 0;
  localparam longint NR = 512;
  logic [31:0] mem_arr [512];
  assign bus.mem_data_r_i = bus.mem_r_en_o ? mem_arr[bus.mem_addr_r_o[10:2]] : 32'hDEADBEEF;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic model_err(input logic [1:0] acc, input logic [31:0] addr);
    longint a = {32'd0, addr};
    longint sz = acc == 2'd0 ? 1 : acc == 2'd1 ? 2 : 4;
    return a < MZ || a >= MZ + 4 * NR || a % sz != 0;
  endfunction
  function automatic logic mem_busy();
    return |{bus.mem_r_en_o, bus.mem_sext_o, bus.mem_acc_r_o, bus.mem_addr_r_o,
             bus.mem_wr_en_o, bus.mem_acc_w_o, bus.mem_addr_w_o, bus.mem_data_w_o};
  endfunction
  task automatic apply(input string name, input logic we, input logic [1:0] acc, input logic sext,
                       input logic [31:0] addr, input logic [31:0] data, input int stall,
                       input logic x_err, input int x_lat);
    logic [31:0] r_data = '0;
    logic        r_err = 1'b0;
    int          lat = -1;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_cm = 0;
    logic [4:0]  proto = '0;
    logic        seen = 1'b0;
    int          st = stall;
    logic [31:0] x_data = (x_err || we) ? 32'h0 : mem_arr[addr[10:2]];
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_acc_i   = acc;
    bus.req_sext_i  = sext;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    if (!bus.req_ready_o) proto[4] = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_data_i  = $urandom;
    for (int c = 1; c <= 30 && !seen; c++) begin
      if (bus.mem_r_en_o && bus.mem_wr_en_o) proto[0] = 1'b1;
      if (bus.req_ready_o) proto[4] = 1'b1;
      n_rd += int'(bus.mem_r_en_o);
      n_wr += int'(bus.mem_wr_en_o);
      if (!x_err && !we && !bus.rsp_valid_o) begin
        if ({bus.mem_r_en_o, bus.mem_sext_o, bus.mem_acc_r_o, bus.mem_addr_r_o} !== {1'b1, sext, acc, addr})
          proto[1] = 1'b1;
      end else if (|{bus.mem_r_en_o, bus.mem_sext_o, bus.mem_acc_r_o, bus.mem_addr_r_o}) proto[1] = 1'b1;
      if (!x_err && we && !bus.rsp_valid_o) begin
        if ({bus.mem_acc_w_o, bus.mem_addr_w_o, bus.mem_data_w_o} !== {acc, addr, data}) proto[2] = 1'b1;
        if (!bus.mem_wr_en_o) n_cm++;
      end else if (|{bus.mem_wr_en_o, bus.mem_acc_w_o, bus.mem_addr_w_o, bus.mem_data_w_o}) proto[2] = 1'b1;
      if (bus.rsp_valid_o && mem_busy()) proto[3] = 1'b1;
      bus.mem_wr_ready_i = bus.mem_wr_en_o && st == 0;
      if (bus.mem_wr_en_o && st > 0) st--;
      if (bus.rsp_valid_o) begin
        seen   = 1'b1;
        lat    = c;
        r_data = bus.rsp_data_o;
        r_err  = bus.rsp_err_o;
      end
      @(negedge clk_i);
    end
    bus.mem_wr_ready_i = 1'b0;
    check({name, " rsp_err"}, 32'(r_err), 32'(x_err));
    check({name, " rsp_data"}, r_data, x_data);
    check({name, " latency"}, lat, x_lat);
    check({name, " rd_en cycles"}, n_rd, (!x_err && !we) ? 2 : 0);
    check({name, " wr_en cycles"}, n_wr, (!x_err && we) ? stall + 1 : 0);
    check({name, " commit cycles"}, n_cm, (!x_err && we) ? 1 : 0);
    check({name, " port protocol"}, 32'(proto), 32'h0);
    check({name, " after resp"}, 32'({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_data_o == x_data,
                                       bus.rsp_err_o == x_err}), 32'b0111);
  endtask
  vec_t vecs[14];
  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_acc_i      = 2'b00;
    bus.req_sext_i     = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_data_i     = '0;
    bus.mem_wr_ready_i = 1'b0;
    for (int i = 0; i < 512; i++) mem_arr[i] = $urandom | 32'h1;
    mem_arr[4] = 32'h8899AABB;
    vecs[0]  = '{"word load 0x10",      1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        0, 1'b0, 3};
    vecs[1]  = '{"sbyte load 0x13",     1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        0, 1'b0, 3};
    vecs[2]  = '{"half store 0x22",     1'b1, 2'd1, 1'b0, 32'h22,       32'h1234,     2, 1'b0, 5};
    vecs[3]  = '{"word load 0x6",       1'b0, 2'd2, 1'b0, 32'h6,        32'h0,        0, 1'b1, 1};
    vecs[4]  = '{"word store 0x800",    1'b1, 2'd2, 1'b0, 32'h800,      32'hA5A5A5A5, 0, 1'b1, 1};
    vecs[5]  = '{"word load top",       1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        0, 1'b1, 1};
    vecs[6]  = '{"half load 0x21",      1'b0, 2'd1, 1'b0, 32'h21,       32'h0,        0, 1'b1, 1};
    vecs[7]  = '{"word load 0x7FC",     1'b0, 2'd2, 1'b0, 32'h7FC,      32'h0,        0, 1'b0, 3};
    vecs[8]  = '{"byte load 0x7FF",     1'b0, 2'd0, 1'b0, 32'h7FF,      32'h0,        0, 1'b0, 3};
    vecs[9]  = '{"byte store 0x800",    1'b1, 2'd0, 1'b0, 32'h800,      32'h11,       0, 1'b1, 1};
    vecs[10] = '{"acc3 load 0x402",     1'b0, 2'd3, 1'b0, 32'h402,      32'h0,        0, 1'b1, 1};
    vecs[11] = '{"acc3 load 0x404",     1'b0, 2'd3, 1'b0, 32'h404,      32'h0,        0, 1'b0, 3};
    vecs[12] = '{"word store 0x0",      1'b1, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 0, 1'b0, 3};
    vecs[13] = '{"shalf load 0x7FE",    1'b0, 2'd1, 1'b1, 32'h7FE,      32'h0,        0, 1'b0, 3};
    repeat (2) @(negedge clk_i);
    check("reset rsp", 32'({bus.rsp_valid_o, bus.rsp_err_o}), 32'h0);
    check("reset rsp_data", bus.rsp_data_o, 32'h0);
    check("reset mem ports", 32'(mem_busy()), 32'h0);
    rstn_i = 1'b1;
    check("ready after reset", 32'(bus.req_ready_o), 32'h1);
    for (int i = 0; i < 14; i++)
      apply(vecs[i].name, vecs[i].we, vecs[i].acc, vecs[i].sext, vecs[i].addr, vecs[i].data,
            vecs[i].stall, vecs[i].exp_err, vecs[i].exp_lat);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_acc_i      = 2'd2;
    bus.req_addr_i     = 32'h100;
    bus.req_data_i     = 32'h55AA55AA;
    bus.mem_wr_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    check("rst seq store wr_en", 32'(bus.mem_wr_en_o), 32'h1);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.mem_wr_ready_i = 1'b0;
    check("rst seq commit hold", 32'({bus.mem_wr_en_o, bus.mem_addr_w_o == 32'h100, bus.mem_data_w_o == 32'h55AA55AA}), 32'b011);
    check("rst seq rsp_data before", 32'(bus.rsp_data_o != 32'h0), 32'h1);
    rstn_i = 1'b0;
    #1;
    check("rst seq rsp", 32'({bus.rsp_valid_o, bus.rsp_err_o}), 32'h0);
    check("rst seq rsp_data", bus.rsp_data_o, 32'h0);
    check("rst seq mem ports", 32'(mem_busy()), 32'h0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    check("rst seq ready", 32'(bus.req_ready_o), 32'h1);
    begin
      int n_rsp = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_i);
        n_rsp += int'(bus.rsp_valid_o);
      end
      check("rst seq no response", n_rsp, 0);
    end
    apply("post-reset load 0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 3);
    for (int i = 0; i < 60; i++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [1:0]  acc = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 'h81F));
      int          stall = $urandom_range(0, 3);
      logic        x_err = model_err(acc, addr);
      apply($sformatf("rand%0d", i), we, acc, 1'($urandom_range(0, 1)), addr, $urandom, stall,
            x_err, x_err ? 1 : we ? 3 + stall : 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
